// File: rtl/apb4_timer.sv
// APB4 general-purpose timer: prescaled 32-bit up-counter with compare match,
// one-shot or periodic mode and a registered level interrupt.
module apb4_timer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    input  logic [2:0]          pprot,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic                irq_out
);

    localparam logic [4:0] OFF_CTRL  = 5'h00;
    localparam logic [4:0] OFF_PRESC = 5'h04;
    localparam logic [4:0] OFF_COUNT = 5'h08;
    localparam logic [4:0] OFF_CMP   = 5'h0C;
    localparam logic [4:0] OFF_STAT  = 5'h10;

    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_val,
                                                  input logic [DATA_W-1:0] wdat,
                                                  input logic [DATA_W/8-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (strb[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
        end
        return res;
    endfunction

    logic                r_en;
    logic                r_periodic;
    logic                r_ie;
    logic [PRESC_W-1:0]  r_presc;
    logic [PRESC_W-1:0]  r_pcnt;
    logic [DATA_W-1:0]   r_count;
    logic [DATA_W-1:0]   r_cmp;
    logic                r_pend;
    logic                r_irq;
    logic [DATA_W-1:0]   r_prdata;

    logic [4:0]          w_off;
    logic                w_access;
    logic                w_bad;
    logic                w_wr;
    logic                w_rd;
    logic                w_wr_ctrl;
    logic                w_wr_presc;
    logic                w_wr_count;
    logic                w_wr_cmp;
    logic                w_w1c;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_merge;
    logic                w_tick;
    logic                w_match;
    logic                w_unused;

    assign w_unused   = ^{paddr[ADDR_W-1:5], pprot};

    assign w_off      = paddr[4:0];
    assign w_access   = psel & penable;
    assign w_bad      = (w_off[1:0] != 2'b00) | (w_off > OFF_STAT);
    assign w_wr       = w_access & pwrite & ~w_bad;
    assign w_rd       = w_access & ~pwrite;
    assign w_wr_ctrl  = w_wr & (w_off == OFF_CTRL);
    assign w_wr_presc = w_wr & (w_off == OFF_PRESC);
    assign w_wr_count = w_wr & (w_off == OFF_COUNT);
    assign w_wr_cmp   = w_wr & (w_off == OFF_CMP);
    assign w_w1c      = w_wr & (w_off == OFF_STAT) & pstrb[0] & pwdata[0];

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:  w_rdata = {{(DATA_W-3){1'b0}}, r_ie, r_periodic, r_en};
            OFF_PRESC: w_rdata = DATA_W'(r_presc);
            OFF_COUNT: w_rdata = r_count;
            OFF_CMP:   w_rdata = r_cmp;
            OFF_STAT:  w_rdata = {{(DATA_W-1){1'b0}}, r_pend};
            default:   w_rdata = '0;
        endcase
    end

    // Partial-strobe writes merge into the addressed register's current value.
    assign w_merge = f_merge(w_rdata, pwdata, pstrb);

    assign w_tick  = r_en & (r_pcnt == r_presc);
    // A COUNT write in the same cycle suppresses match evaluation.
    assign w_match = w_tick & ~w_wr_count & (r_count == r_cmp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_ie       <= 1'b0;
            r_presc    <= '0;
            r_pcnt     <= '0;
            r_count    <= '0;
            r_cmp      <= '0;
            r_pend     <= 1'b0;
            r_irq      <= 1'b0;
            r_prdata   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= w_merge[0];
                r_periodic <= w_merge[1];
                r_ie       <= w_merge[2];
            end else if (w_match && !r_periodic) begin
                r_en <= 1'b0;
            end

            if (w_wr_presc) r_presc <= w_merge[PRESC_W-1:0];
            if (w_wr_cmp)   r_cmp   <= w_merge;

            if (w_wr_count)  r_count <= w_merge;
            else if (w_tick) r_count <= w_match ? '0 : r_count + 1'b1;

            if (w_match)    r_pend <= 1'b1;
            else if (w_w1c) r_pend <= 1'b0;

            // Restarting on CTRL/PRESC writes makes the first tick a full period away.
            if (!r_en || w_wr_ctrl || w_wr_presc || w_tick) r_pcnt <= '0;
            else                                             r_pcnt <= r_pcnt + 1'b1;

            r_irq <= r_pend & r_ie;

            if (w_rd) r_prdata <= w_bad ? '0 : w_rdata;
        end
    end

    assign prdata  = r_prdata;
    assign pready  = 1'b1;
    assign pslverr = w_access & w_bad;
    assign irq_out = r_irq;

endmodule

// File: tb/tb_apb4_timer.sv
// Bench for apb4_timer: directed scenarios with hand-derived timing plus a
// randomized run compared against a cycle-level behavioural model.
module tb_apb4_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq_out;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [31:0] rd_data;
    logic        rd_err;

    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_PRESC = 32'h04;
    localparam logic [31:0] A_COUNT = 32'h08;
    localparam logic [31:0] A_CMP   = 32'h0C;
    localparam logic [31:0] A_STAT  = 32'h10;

    apb4_timer #(.ADDR_W(32), .DATA_W(32), .PRESC_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pprot   (pprot),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural reference: prescaler as a free-running phase with modulo arithmetic.
    logic        m_en, m_per, m_ie, m_pend, m_irq;
    logic [15:0] m_presc;
    logic [31:0] m_count, m_cmp, m_prdata;
    int unsigned m_phase;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[4:0] > 5'h10);
    endfunction

    function automatic logic [31:0] m_reg(input logic [4:0] off);
        case (off)
            5'h00:   return {29'b0, m_ie, m_per, m_en};
            5'h04:   return {16'b0, m_presc};
            5'h08:   return m_count;
            5'h0C:   return m_cmp;
            5'h10:   return {31'b0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [4:0]  off;
        logic        acc, bad, wr, tick, match, wcount;
        logic [31:0] old, wv;
        if (rst) begin
            m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_irq = 0;
            m_presc = 0; m_count = 0; m_cmp = 0; m_prdata = 0; m_phase = 0;
        end else begin
            off    = paddr[4:0];
            acc    = psel && penable;
            bad    = addr_bad(paddr);
            wr     = acc && pwrite && !bad;
            old    = m_reg(off);
            wv     = old;
            for (int b = 0; b < 4; b++) if (pstrb[b]) wv[b*8 +: 8] = pwdata[b*8 +: 8];
            tick   = m_en && ((m_phase % (int'(m_presc) + 1)) == int'(m_presc));
            wcount = wr && (off == 5'h08);
            match  = tick && !wcount && (m_count == m_cmp);
            if (acc && !pwrite) m_prdata = bad ? 32'h0 : old;
            m_irq = m_pend && m_ie;
            if (!m_en || (wr && (off == 5'h00 || off == 5'h04))) m_phase = 0;
            else m_phase++;
            if (wcount) m_count = wv;
            else if (tick) m_count = match ? 32'h0 : m_count + 32'd1;
            if (match) m_pend = 1'b1;
            else if (wr && off == 5'h10 && pstrb[0] && pwdata[0]) m_pend = 1'b0;
            if (wr && off == 5'h00) begin
                m_en = wv[0]; m_per = wv[1]; m_ie = wv[2];
            end else if (match && !m_per) m_en = 1'b0;
            if (wr && off == 5'h04) m_presc = wv[15:0];
            if (wr && off == 5'h0C) m_cmp = wv;
        end
    end

    task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        #1 rd_err = pslverr;
        @(posedge clk);
        #1 rd_data = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        apb_xfer(a, 1'b1, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a);
        apb_xfer(a, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic wait_irq_rise(input int start, output int rise);
        rise = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (irq_out) begin rise = cyc - start; break; end
        end
    endtask

    task automatic test_reset;
        n_chk++; if (prdata !== 32'h0) $display("FAIL rst_prdata got %h want 0", prdata); else n_pass++;
        n_chk++; if (irq_out !== 1'b0) $display("FAIL rst_irq got %b want 0", irq_out); else n_pass++;
        n_chk++; if (pready !== 1'b1) $display("FAIL rst_pready got %b want 1", pready); else n_pass++;
        wr(A_CMP, 32'h56); wr(A_COUNT, 32'h55); wr(A_CTRL, 32'h7);
        repeat (6) @(posedge clk);
        #1;
        n_chk++; if (irq_out !== 1'b1) $display("FAIL pre_rst_irq got %b want 1", irq_out); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (irq_out !== 1'b0) $display("FAIL async_rst_irq got %b want 0", irq_out); else n_pass++;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd(32'(i * 4));
            n_chk++;
            if (rd_data !== 32'h0 || rd_err !== 1'b0)
                $display("FAIL rst_reg%0d got %h err %b want 0 err 0", i, rd_data, rd_err);
            else n_pass++;
        end
        wr(A_CMP, 32'hDEAD);
        rd(A_CMP);
        n_chk++; if (rd_data !== 32'hDEAD) $display("FAIL cmp_rd got %h want DEAD", rd_data); else n_pass++;
        rd(32'h14);
        n_chk++; if (rd_err !== 1'b1 || rd_data !== 32'h0)
            $display("FAIL err_0x14 got %h err %b want 0 err 1", rd_data, rd_err); else n_pass++;
        rd(32'h02);
        n_chk++; if (rd_err !== 1'b1) $display("FAIL err_0x02 got err %b want 1", rd_err); else n_pass++;
        wr(32'h0E, 32'h1234);
        n_chk++; if (rd_err !== 1'b1) $display("FAIL err_wr got err %b want 1", rd_err); else n_pass++;
        rd(A_CMP);
        n_chk++; if (rd_data !== 32'hDEAD) $display("FAIL err_wr_nochange got %h want DEAD", rd_data); else n_pass++;
        wr(A_CMP, 32'h0);
    endtask

    task automatic test_periodic;
        int w0, rise;
        wr(A_PRESC, 32'd3); wr(A_CMP, 32'd4); wr(A_CTRL, 32'h7);
        w0 = cyc;
        wait_irq_rise(w0, rise);
        n_chk++; if (rise !== 21) $display("FAIL per_first_irq got %0d want 21", rise); else n_pass++;
        rd(A_COUNT);
        n_chk++; if (rd_data !== 32'h0) $display("FAIL per_count_restart got %h want 0", rd_data); else n_pass++;
        wr(A_STAT, 32'h1);
        @(posedge clk); #1;
        n_chk++; if (irq_out !== 1'b0) $display("FAIL per_irq_clear got %b want 0", irq_out); else n_pass++;
        wait_irq_rise(w0, rise);
        n_chk++; if (rise !== 41) $display("FAIL per_second_irq got %0d want 41", rise); else n_pass++;
        wr(A_CTRL, 32'h0); wr(A_STAT, 32'h1); wr(A_COUNT, 32'h0);
    endtask

    task automatic test_oneshot;
        int w0, rise;
        wr(A_PRESC, 32'd0); wr(A_CMP, 32'd2); wr(A_CTRL, 32'h5);
        w0 = cyc;
        wait_irq_rise(w0, rise);
        n_chk++; if (rise !== 4) $display("FAIL os_irq got %0d want 4", rise); else n_pass++;
        rd(A_CTRL);
        n_chk++; if (rd_data !== 32'h4) $display("FAIL os_ctrl got %h want 4", rd_data); else n_pass++;
        rd(A_COUNT);
        n_chk++; if (rd_data !== 32'h0) $display("FAIL os_count got %h want 0", rd_data); else n_pass++;
        rd(A_STAT);
        n_chk++; if (rd_data !== 32'h1) $display("FAIL os_pend got %h want 1", rd_data); else n_pass++;
        wr(A_STAT, 32'h1);
        n_chk++; if (irq_out !== 1'b1) $display("FAIL os_irq_hold got %b want 1", irq_out); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (irq_out !== 1'b0) $display("FAIL os_irq_drop got %b want 0", irq_out); else n_pass++;
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_strobe_wrap;
        wr(A_CMP, 32'hFFFFFFFF); wr(A_COUNT, 32'h0);
        apb_xfer(A_COUNT, 1'b1, 32'hAABBCCDD, 4'b0010);
        rd(A_COUNT);
        n_chk++; if (rd_data !== 32'h0000CC00) $display("FAIL strb_count got %h want 0000CC00", rd_data); else n_pass++;
        wr(A_COUNT, 32'hFFFFFFFE); wr(A_CMP, 32'd5); wr(A_PRESC, 32'd0); wr(A_CTRL, 32'h3);
        @(posedge clk);
        rd(A_COUNT);
        n_chk++; if (rd_data !== 32'h0) $display("FAIL wrap_count got %h want 0", rd_data); else n_pass++;
        rd(A_STAT);
        n_chk++; if (rd_data !== 32'h0) $display("FAIL wrap_pend got %h want 0", rd_data); else n_pass++;
        wr(A_CTRL, 32'h0); wr(A_STAT, 32'h1);
    endtask

    task automatic test_collisions;
        wr(A_STAT, 32'h1); wr(A_PRESC, 32'd0); wr(A_CMP, 32'd3); wr(A_COUNT, 32'h0); wr(A_CTRL, 32'h3);
        repeat (2) @(posedge clk);
        wr(A_STAT, 32'h1);
        wr(A_CTRL, 32'h0);
        rd(A_STAT);
        n_chk++; if (rd_data !== 32'h1) $display("FAIL col_w1c_vs_match got %h want 1", rd_data); else n_pass++;
        wr(A_STAT, 32'h1); wr(A_PRESC, 32'd2); wr(A_CMP, 32'd5); wr(A_COUNT, 32'd5); wr(A_CTRL, 32'h1);
        @(posedge clk);
        wr(A_COUNT, 32'd7);
        rd(A_COUNT);
        n_chk++; if (rd_data !== 32'd7) $display("FAIL col_count_wr got %h want 7", rd_data); else n_pass++;
        rd(A_STAT);
        n_chk++; if (rd_data !== 32'h0) $display("FAIL col_no_match got %h want 0", rd_data); else n_pass++;
        rd(A_CTRL);
        n_chk++; if (rd_data !== 32'h1) $display("FAIL col_en_kept got %h want 1", rd_data); else n_pass++;
        wr(A_CTRL, 32'h0); wr(A_STAT, 32'h1);
    endtask

    task automatic test_presc_restart;
        wr(A_PRESC, 32'd7); wr(A_CMP, 32'hFFFFFFFF); wr(A_COUNT, 32'h0); wr(A_STAT, 32'h1);
        wr(A_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        wr(A_PRESC, 32'd9);
        repeat (7) @(posedge clk);
        rd(A_COUNT);
        n_chk++; if (rd_data !== 32'h0) $display("FAIL presc_before_tick got %h want 0", rd_data); else n_pass++;
        rd(A_COUNT);
        n_chk++; if (rd_data !== 32'h1) $display("FAIL presc_after_tick got %h want 1", rd_data); else n_pass++;
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          r;
        logic        is_wr;
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 11);
            a = (r < 10) ? 32'($urandom_range(0, 4) * 4) : ((r == 10) ? 32'h14 : 32'h0A);
            case (a[4:0])
                5'h04:   d = 32'($urandom_range(0, 3));
                5'h08:   d = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 12));
                5'h0C:   d = 32'($urandom_range(0, 12));
                default: d = $urandom();
            endcase
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            is_wr = ($urandom_range(0, 1) == 1);
            apb_xfer(a, is_wr, d, s);
            n_chk++;
            if (rd_err !== addr_bad(a)) $display("FAIL rnd_slverr it%0d addr %h got %b want %b", it, a, rd_err, addr_bad(a));
            else n_pass++;
            if (!is_wr) begin
                n_chk++;
                if (rd_data !== m_prdata) $display("FAIL rnd_rdata it%0d addr %h got %h want %h", it, a, rd_data, m_prdata);
                else n_pass++;
            end
            n_chk++;
            if (irq_out !== m_irq) $display("FAIL rnd_irq it%0d got %b want %b", it, irq_out, m_irq);
            else n_pass++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
        rd_data = 32'h0; rd_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        test_reset;
        test_periodic;
        test_oneshot;
        test_strobe_wrap;
        test_collisions;
        test_presc_restart;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb4_timer.md
Name: apb4_timer

Overview:
- APB4 slave general-purpose timer on the peripheral APB segment, downstream of the peripheral axi_to_apb bridge, beside the UART.
- Provides a prescaled 32-bit up-counter with a compare match, one-shot or periodic mode, and a level interrupt.
- The interrupt is routed to a PLIC source input, irq_source[1].

Parameters:
- ADDR_W, 32, APB address width; equals PADDR_SIZE.
- DATA_W, 32, APB data width; equals XLEN. Only 32 is supported.
- PRESC_W, 16, prescaler register width.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- paddr  in  ADDR_W  APB address; only bits [4:0] are decoded.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte write strobes.
- pprot  in  3  ignored.
- prdata  out  DATA_W  read data.
- pready  out  1  ready.
- pslverr  out  1  error response.
- irq_out  out  1  registered timer interrupt.

Behaviour:
- Reset values: all registers 0, prdata=0, pslverr=0, irq_out=0. pready is tied to 1, so every access completes in its access phase with zero wait states.
- Register map (offset, fields):
  - 0x00 CTRL: [0] EN, [1] PERIODIC, [2] IE; other bits read 0.
  - 0x04 PRESC: [PRESC_W-1:0] divider.
  - 0x08 COUNT: 32-bit counter, read/write.
  - 0x0C CMP: 32-bit compare value.
  - 0x10 STATUS: [0] PEND, write-1-to-clear.
- Access commit: a write commits when psel & penable & pwrite. Only bytes whose pstrb bit is set are updated. Reads return the current register value registered onto prdata in the same access phase; prdata holds its value between accesses.
- Error responses: pslverr=1 during the access phase when paddr[1:0]!=0 or the offset is above 0x10. An errored write changes no state; an errored read returns 0.
- Prescaler:
  - An internal counter pcnt (PRESC_W bits) runs only while EN=1.
  - tick=1 for one cycle when pcnt==PRESC; pcnt then wraps to 0, otherwise it increments. The tick rate is clk/(PRESC+1); PRESC=0 gives a tick every cycle.
  - pcnt is cleared when EN=0 and on any write to PRESC or CTRL.
- Counter on tick:
  - If COUNT==CMP: PEND<=1 and COUNT<=0. If PERIODIC=0, EN is also cleared (one-shot stop).
  - Otherwise COUNT<=COUNT+1, wrapping modulo 2^32 from 0xFFFFFFFF to 0 with no flag.
- Priorities (same cycle):
  - An APB write to COUNT beats the tick update; the written value is loaded and the match is not evaluated that cycle.
  - A match setting PEND beats a W1C clear of PEND, so PEND stays 1.
  - A CTRL write beats the one-shot auto-clear of EN.
- Interrupt: irq_out <= PEND & IE, a register with 1-cycle latency. It is level-sensitive and stays high until PEND is cleared or IE=0.
- Reset mid-operation: asserting rst asynchronously forces all state to its reset value. An in-flight APB access is dropped and the master is expected to be reset too.
- Expected RTL size is about 150-250 lines: register file, prescaler, counter and compare, APB decode.

Test Plan:
- Reset and defaults: assert rst mid-count with COUNT=0x55 → all reads return 0, irq_out=0; read offset 0x14 → pslverr=1, prdata=0; read paddr=0x02 → pslverr=1.
- Periodic match: PRESC=3, CMP=4, CTRL=0x7 → PEND sets after 5 ticks, i.e. 20 clk after the CTRL write. irq_out rises 1 cycle after PEND, COUNT restarts at 0, and the next PEND comes 20 clk later.
- One-shot and W1C: CTRL=0x5, PRESC=0, CMP=2 → PEND=1 after 3 cycles, CTRL reads 0x4 (EN cleared), COUNT stays 0. Writing STATUS=1 clears PEND and irq_out drops the next cycle.
- Byte strobes and wrap: write CMP=0xFFFFFFFF, then COUNT=0xAABBCCDD with pstrb=0b0010 → COUNT=0x0000CC00. Then set COUNT=0xFFFFFFFE, CMP=5, PRESC=0, CTRL=0x3 → COUNT reads 0 two ticks later and PEND=0.
- Collisions: a W1C to STATUS in the cycle a match fires → PEND remains 1. A COUNT=7 write in the cycle of a tick → COUNT reads 7, with no increment and no match that cycle.
- Prescaler restart: write PRESC=9 when pcnt=5 → the next tick arrives exactly 10 cycles after the write.
